// File: rtl/bitserial_mac_array_if.sv
// Beat and result handshake bundle for the bit-serial MAC array.
// master drives operands and config; slave is the array itself.
interface bitserial_mac_array_if #(
  parameter int LANES    = 16,
  parameter int MAX_PREC = 8,
  parameter int ACC_W    = 32
);
  localparam int PW = $clog2(MAX_PREC + 1);

  logic             start;
  logic [PW-1:0]    prec_i;
  logic [PW-1:0]    prec_w;
  logic             SignI;
  logic             SignW;
  logic             bin;
  logic             acc_keep;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] I_plane;
  logic [LANES-1:0] W_plane;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             busy;

  modport master (
    output start, prec_i, prec_w, SignI, SignW, bin, acc_keep,
    output in_valid, I_plane, W_plane, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  start, prec_i, prec_w, SignI, SignW, bin, acc_keep,
    input  in_valid, I_plane, W_plane, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/bitserial_mac_array.sv
// Bit-serial LANES-wide dot product, one (act plane, weight plane)
// pair per beat; AND mode with signed MSB planes, or XNOR +-1 mode.
module bitserial_mac_array #(
  parameter int LANES    = 16,
  parameter int MAX_PREC = 8,
  parameter int ACC_W    = 32
) (
  input logic clk,
  input logic rst,
  bitserial_mac_array_if.slave bus
);
  localparam int PW = $clog2(MAX_PREC + 1);
  localparam int CW = $clog2(LANES + 1);
  localparam logic [PW-1:0] MAXP = PW'(MAX_PREC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    pi, pw, ci, cw;
  logic             si, sw, bm;
  logic             rdy_q, vld_q, busy_q;
  logic [ACC_W-1:0] acc, term, mag;
  logic [CW-1:0]    pand, pxn;
  logic             ilast, wlast, last, neg;

  function automatic logic [PW-1:0] clamp(input logic [PW-1:0] p);
    if (p == '0) return PW'(1);
    if (p > MAXP) return MAXP;
    return p;
  endfunction

  always_comb begin
    pand = '0;
    pxn  = '0;
    for (int k = 0; k < LANES; k++) begin
      pand = pand + CW'(bus.I_plane[k] & bus.W_plane[k]);
      pxn  = pxn + CW'(~(bus.I_plane[k] ^ bus.W_plane[k]));
    end
  end

  assign ilast = (ci == pi - PW'(1));
  assign wlast = (cw == pw - PW'(1));
  assign last  = ilast & wlast;
  assign mag   = ACC_W'(pand) << ({1'b0, ci} + {1'b0, cw});
  // MSB planes carry negative weight; both MSBs together cancel.
  assign neg   = (si & ilast) ^ (sw & wlast);
  assign term  = bm ? ACC_W'({pxn, 1'b0}) - ACC_W'(LANES)
                    : (neg ? -mag : mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      pi     <= '0;
      pw     <= '0;
      ci     <= '0;
      cw     <= '0;
      si     <= 1'b0;
      sw     <= 1'b0;
      bm     <= 1'b0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            pi     <= bus.bin ? PW'(1) : clamp(bus.prec_i);
            pw     <= bus.bin ? PW'(1) : clamp(bus.prec_w);
            si     <= bus.SignI & ~bus.bin;
            sw     <= bus.SignW & ~bus.bin;
            bm     <= bus.bin;
            ci     <= '0;
            cw     <= '0;
            if (!bus.acc_keep) acc <= '0;
            state  <= RUN;
            rdy_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            acc <= acc + term;
            if (last) begin
              ci    <= '0;
              cw    <= '0;
              state <= DONE;
              rdy_q <= 1'b0;
              vld_q <= 1'b1;
            end else if (ilast) begin
              ci <= '0;
              cw <= cw + PW'(1);
            end else begin
              ci <= ci + PW'(1);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state  <= IDLE;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.result    = acc;
endmodule
